// File: rtl/clock_pkg.sv
// Shared types and helpers for the set-time clock controller.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        EDIT_H   = 3'd1,
        EDIT_M   = 3'd2,
        COMMIT_H = 3'd3,
        COMMIT_M = 3'd4
    } ctrl_state_t;

    localparam int unsigned HOURS_PER_DAY = 24;
    localparam int unsigned MINS_PER_HOUR = 60;

    // Out-of-range hour from the counter starts the edit at 0.
    function automatic logic [4:0] clamp_hour(input logic [4:0] h);
        return (h > 5'(HOURS_PER_DAY - 1)) ? 5'd0 : h;
    endfunction

    // Out-of-range minute from the counter starts the edit at 0.
    function automatic logic [5:0] clamp_min(input logic [5:0] m);
        return (m > 6'(MINS_PER_HOUR - 1)) ? 6'd0 : m;
    endfunction

    // Hour increment, wrapping 23 -> 0 (anything >=23 wraps, so garbage cannot escape).
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h >= 5'(HOURS_PER_DAY - 1)) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute increment, wrapping 59 -> 0.
    function automatic logic [5:0] next_min(input logic [5:0] m);
        return (m >= 6'(MINS_PER_HOUR - 1)) ? 6'd0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-key conditioner: 2-flop synchronizer, stable-count debouncer and a
// registered one-cycle press pulse on each debounced 1->0 transition.
module key_debounce
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             level_next_s;

    // Stable-count: any disagreement with the accepted level counts up; a
    // return to the accepted level (bounce) restarts the count.
    always_comb begin
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        if (sync2_r == level_r) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_next_s   = {CNT_W{1'b0}};
            level_next_s = sync2_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchronizer, debounce state and press-pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            level_r   <= 1'b1;
            level_d_r <= 1'b1;
            press_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            sync1_r   <= key_n;
            sync2_r   <= sync1_r;
            level_r   <= level_next_s;
            level_d_r <= level_r;
            press_r   <= level_d_r & ~level_r;
            cnt_r     <= cnt_next_s;
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/clock_ctrl.sv
// Set-time controller: debounced keys drive a mode FSM that freezes the
// wall-clock counter during edit and commits hour/minute on s_clk edges.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_S       = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       s_clk,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    output logic       enable,
    output logic       reset_h,
    output logic       reset_m,
    output logic [5:0] set,
    output logic       blink_h,
    output logic       blink_m
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_S);

    ctrl_state_t       state_r;
    ctrl_state_t       state_next_s;
    logic [4:0]        edit_h_r;
    logic [4:0]        edit_h_next_s;
    logic [5:0]        edit_m_r;
    logic [5:0]        edit_m_next_s;
    logic [IDLE_W-1:0] idle_r;
    logic [IDLE_W-1:0] idle_next_s;
    logic              sclk_q1_r;
    logic              sclk_q2_r;
    logic              s_rise_s;
    logic              mode_press_s;
    logic              inc_press_s;
    logic              level_mode_s;
    logic              level_inc_s;
    logic              idle_expired_s;
    logic              in_edit_next_s;
    logic              enable_s;
    logic              reset_h_s;
    logic              reset_m_s;
    logic [5:0]        set_s;
    logic              blink_h_s;
    logic              blink_m_s;
    logic              key_levels_unused_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_mode),
        .level   (level_mode_s),
        .press   (mode_press_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_inc),
        .level   (level_inc_s),
        .press   (inc_press_s)
    );

    // Only press events steer the controller; debounced levels stay unused.
    assign key_levels_unused_s = level_mode_s & level_inc_s;

    assign s_rise_s       = sclk_q1_r & ~sclk_q2_r;
    assign idle_expired_s = (idle_r >= IDLE_MAX);

    // Next-state and edit-register logic; mode always wins over inc.
    always_comb begin
        state_next_s  = state_r;
        edit_h_next_s = edit_h_r;
        edit_m_next_s = edit_m_r;
        case (state_r)
            RUN: begin
                if (mode_press_s) begin
                    state_next_s  = EDIT_H;
                    edit_h_next_s = clamp_hour(hour);
                end else begin
                    state_next_s = RUN;
                end
            end
            EDIT_H: begin
                if (idle_expired_s) begin
                    state_next_s = RUN;
                end else if (mode_press_s) begin
                    state_next_s  = EDIT_M;
                    edit_m_next_s = clamp_min(min);
                end else if (inc_press_s) begin
                    edit_h_next_s = next_hour(edit_h_r);
                end else begin
                    state_next_s = EDIT_H;
                end
            end
            EDIT_M: begin
                if (idle_expired_s) begin
                    state_next_s = RUN;
                end else if (mode_press_s) begin
                    state_next_s = COMMIT_H;
                end else if (inc_press_s) begin
                    edit_m_next_s = next_min(edit_m_r);
                end else begin
                    state_next_s = EDIT_M;
                end
            end
            COMMIT_H: begin
                if (s_rise_s) begin
                    state_next_s = COMMIT_M;
                end else begin
                    state_next_s = COMMIT_H;
                end
            end
            COMMIT_M: begin
                if (s_rise_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = COMMIT_M;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // Idle timer: counts seconds spent untouched in an edit state, saturating.
    always_comb begin
        idle_next_s    = idle_r;
        in_edit_next_s = (state_next_s == EDIT_H) || (state_next_s == EDIT_M);
        if (!in_edit_next_s) begin
            idle_next_s = {IDLE_W{1'b0}};
        end else if (state_next_s != state_r) begin
            idle_next_s = {IDLE_W{1'b0}};
        end else if (mode_press_s || inc_press_s) begin
            idle_next_s = {IDLE_W{1'b0}};
        end else if (s_rise_s && (idle_r != IDLE_MAX)) begin
            idle_next_s = idle_r + IDLE_W'(1);
        end else begin
            idle_next_s = idle_r;
        end
    end

    // Output decode from the current state; registered one cycle later.
    always_comb begin
        enable_s  = 1'b1;
        reset_h_s = 1'b0;
        reset_m_s = 1'b0;
        set_s     = 6'd0;
        blink_h_s = 1'b0;
        blink_m_s = 1'b0;
        case (state_r)
            RUN: begin
                enable_s = 1'b1;
            end
            EDIT_H: begin
                enable_s  = 1'b0;
                blink_h_s = 1'b1;
            end
            EDIT_M: begin
                enable_s  = 1'b0;
                blink_m_s = 1'b1;
            end
            COMMIT_H: begin
                reset_h_s = 1'b1;
                set_s     = {1'b0, edit_h_r};
            end
            COMMIT_M: begin
                reset_m_s = 1'b1;
                set_s     = edit_m_r;
            end
            default: begin
                enable_s = 1'b1;
            end
        endcase
    end

    // FSM state, edit values, idle timer and s_clk synchronizer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= RUN;
            edit_h_r  <= 5'd0;
            edit_m_r  <= 6'd0;
            idle_r    <= {IDLE_W{1'b0}};
            sclk_q1_r <= 1'b1;
            sclk_q2_r <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            edit_h_r  <= edit_h_next_s;
            edit_m_r  <= edit_m_next_s;
            idle_r    <= idle_next_s;
            sclk_q1_r <= s_clk;
            sclk_q2_r <= sclk_q1_r;
        end
    end

    // Registered outputs toward the counter and the display.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable  <= 1'b1;
            reset_h <= 1'b0;
            reset_m <= 1'b0;
            set     <= 6'd0;
            blink_h <= 1'b0;
            blink_m <= 1'b0;
        end else begin
            enable  <= enable_s;
            reset_h <= reset_h_s;
            reset_m <= reset_m_s;
            set     <= set_s;
            blink_h <= blink_h_s;
            blink_m <= blink_m_s;
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed self-checking bench for clock_ctrl (DEBOUNCE_CYCLES=4, TIMEOUT_S=3).
module tb_clock_ctrl;
    import clock_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       key_mode = 1'b1;
    logic       key_inc = 1'b1;
    logic       s_clk = 1'b0;
    logic [4:0] hour = 5'd0;
    logic [5:0] min = 6'd0;
    logic       enable;
    logic       reset_h;
    logic       reset_m;
    logic [5:0] set;
    logic       blink_h;
    logic       blink_m;

    logic       s_en = 1'b0;
    int         sc_cnt = 0;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    clock_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_S(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .s_clk    (s_clk),
        .hour     (hour),
        .min      (min),
        .enable   (enable),
        .reset_h  (reset_h),
        .reset_m  (reset_m),
        .set      (set),
        .blink_h  (blink_h),
        .blink_m  (blink_m)
    );

    always #5 clk = ~clk;

    // Second clock: period 40 clk cycles while enabled, held low otherwise.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (s_en) begin
                sc_cnt = sc_cnt + 1;
                if (sc_cnt == 20) begin
                    s_clk  = ~s_clk;
                    sc_cnt = 0;
                end
            end else begin
                s_clk  = 1'b0;
                sc_cnt = 0;
            end
        end
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        key_mode = 1'b1;
        key_inc  = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    // Hold the selected keys low long enough for one press, then release.
    task automatic press(input logic m, input logic i);
        key_mode = m ? 1'b0 : 1'b1;
        key_inc  = i ? 1'b0 : 1'b1;
        tick(10);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        s_en = 1'b0;
        apply_reset();
        chk_cnt++; if (enable !== 1'b1) $display("FAIL rst_enable: got %b want 1", enable); else pass_cnt++;
        chk_cnt++; if (reset_h !== 1'b0 || reset_m !== 1'b0) $display("FAIL rst_loads: got %b%b want 00", reset_h, reset_m); else pass_cnt++;
        chk_cnt++; if (set !== 6'd0) $display("FAIL rst_set: got %0d want 0", set); else pass_cnt++;
        chk_cnt++; if (blink_h !== 1'b0 || blink_m !== 1'b0) $display("FAIL rst_blink: got %b%b want 00", blink_h, blink_m); else pass_cnt++;
        chk_cnt++; if (dut.state_r !== RUN) $display("FAIL rst_state: got %0d want %0d", dut.state_r, RUN); else pass_cnt++;
        chk_cnt++; if (dut.edit_h_r !== 5'd0 || dut.edit_m_r !== 6'd0) $display("FAIL rst_edit: got %0d/%0d want 0/0", dut.edit_h_r, dut.edit_m_r); else pass_cnt++;
    endtask

    task automatic test_bounce();
        int pulses;
        int pulse_at;
        ctrl_state_t st8;
        logic en9;
        s_en = 1'b0;
        apply_reset();
        pulses   = 0;
        pulse_at = -1;
        st8      = RUN;
        en9      = 1'b1;
        for (int j = 0; j < 4; j++) begin
            key_mode = (j % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        key_mode = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            if (dut.u_key_mode.press === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
            if (k == 8) st8 = dut.state_r;
            if (k == 9) en9 = enable;
        end
        chk_cnt++; if (pulses !== 1) $display("FAIL bounce_count: got %0d pulses want 1", pulses); else pass_cnt++;
        chk_cnt++; if (pulse_at !== 7) $display("FAIL bounce_latency: got %0d cycles want 7", pulse_at); else pass_cnt++;
        chk_cnt++; if (st8 !== EDIT_H) $display("FAIL bounce_state: got %0d want %0d", st8, EDIT_H); else pass_cnt++;
        chk_cnt++; if (en9 !== 1'b0) $display("FAIL bounce_enable: got %b want 0", en9); else pass_cnt++;
        key_mode = 1'b1;
        tick(10);
    endtask

    task automatic test_full_set();
        int w;
        logic both;
        s_en = 1'b1;
        hour = 5'd22;
        min  = 6'd58;
        apply_reset();
        both = 1'b0;
        press(1'b1, 1'b0);
        chk_cnt++; if (dut.edit_h_r !== 5'd22) $display("FAIL full_edit_h_load: got %0d want 22", dut.edit_h_r); else pass_cnt++;
        press(1'b0, 1'b1);
        chk_cnt++; if (dut.edit_h_r !== 5'd23) $display("FAIL full_edit_h_inc: got %0d want 23", dut.edit_h_r); else pass_cnt++;
        press(1'b0, 1'b1);
        chk_cnt++; if (dut.edit_h_r !== 5'd0) $display("FAIL full_edit_h_wrap: got %0d want 0", dut.edit_h_r); else pass_cnt++;
        press(1'b1, 1'b0);
        chk_cnt++; if (dut.edit_m_r !== 6'd58) $display("FAIL full_edit_m_load: got %0d want 58", dut.edit_m_r); else pass_cnt++;
        press(1'b0, 1'b1);
        chk_cnt++; if (dut.edit_m_r !== 6'd59) $display("FAIL full_edit_m_inc: got %0d want 59", dut.edit_m_r); else pass_cnt++;
        press(1'b0, 1'b1);
        chk_cnt++; if (dut.edit_m_r !== 6'd0) $display("FAIL wrap_edit_m: got %0d want 0", dut.edit_m_r); else pass_cnt++;
        chk_cnt++; if (blink_m !== 1'b1 || blink_h !== 1'b0) $display("FAIL wrap_blink: got h%b m%b want h0 m1", blink_h, blink_m); else pass_cnt++;
        key_mode = 1'b0;
        w = 0;
        while (reset_h !== 1'b1 && w < 20) begin tick(1); w++; end
        key_mode = 1'b1;
        chk_cnt++; if (reset_h !== 1'b1) $display("FAIL full_reset_h: got %b want 1 (timeout)", reset_h); else pass_cnt++;
        chk_cnt++; if (set !== 6'd0 || enable !== 1'b1 || reset_m !== 1'b0) $display("FAIL full_commit_h: set %0d en %b rm %b want 0 1 0", set, enable, reset_m); else pass_cnt++;
        w = 0;
        while (reset_m !== 1'b1 && w < 60) begin
            if (reset_h === 1'b1 && reset_m === 1'b1) both = 1'b1;
            tick(1); w++;
        end
        chk_cnt++; if (reset_m !== 1'b1 || reset_h !== 1'b0) $display("FAIL full_reset_m: got rh%b rm%b want rh0 rm1", reset_h, reset_m); else pass_cnt++;
        chk_cnt++; if (set !== 6'd0 || enable !== 1'b1) $display("FAIL full_commit_m: set %0d en %b want 0 1", set, enable); else pass_cnt++;
        w = 0;
        while (reset_m !== 1'b0 && w < 60) begin
            if (reset_h === 1'b1 && reset_m === 1'b1) both = 1'b1;
            tick(1); w++;
        end
        chk_cnt++; if (dut.state_r !== RUN || enable !== 1'b1 || reset_m !== 1'b0) $display("FAIL full_run: state %0d en %b rm %b want 0 1 0", dut.state_r, enable, reset_m); else pass_cnt++;
        chk_cnt++; if (both !== 1'b0) $display("FAIL full_mutex: got %b want 0", both); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic load_seen;
        logic left_early;
        int w;
        s_en = 1'b0;
        hour = 5'd30;
        min  = 6'd10;
        apply_reset();
        press(1'b1, 1'b0);
        chk_cnt++; if (dut.edit_h_r !== 5'd0) $display("FAIL timeout_hour_clamp: got %0d want 0", dut.edit_h_r); else pass_cnt++;
        load_seen  = 1'b0;
        left_early = 1'b0;
        s_en = 1'b1;
        for (int k = 0; k < 95; k++) begin
            tick(1);
            if (reset_h === 1'b1 || reset_m === 1'b1) load_seen = 1'b1;
            if (dut.state_r !== EDIT_H) left_early = 1'b1;
        end
        chk_cnt++; if (left_early !== 1'b0 || enable !== 1'b0) $display("FAIL timeout_early: left %b en %b want 0 0", left_early, enable); else pass_cnt++;
        w = 0;
        while (dut.state_r !== RUN && w < 30) begin
            tick(1); w++;
            if (reset_h === 1'b1 || reset_m === 1'b1) load_seen = 1'b1;
        end
        chk_cnt++; if (dut.state_r !== RUN) $display("FAIL timeout_run: got %0d want %0d", dut.state_r, RUN); else pass_cnt++;
        tick(1);
        if (reset_h === 1'b1 || reset_m === 1'b1) load_seen = 1'b1;
        chk_cnt++; if (enable !== 1'b1 || blink_h !== 1'b0) $display("FAIL timeout_enable: en %b bh %b want 1 0", enable, blink_h); else pass_cnt++;
        chk_cnt++; if (load_seen !== 1'b0) $display("FAIL timeout_noload: got %b want 0", load_seen); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        s_en = 1'b0;
        hour = 5'd9;
        min  = 6'd63;
        apply_reset();
        press(1'b0, 1'b1);
        chk_cnt++; if (dut.state_r !== RUN || enable !== 1'b1) $display("FAIL run_inc_ignored: state %0d en %b want 0 1", dut.state_r, enable); else pass_cnt++;
        press(1'b1, 1'b0);
        chk_cnt++; if (dut.edit_h_r !== 5'd9) $display("FAIL simul_load: got %0d want 9", dut.edit_h_r); else pass_cnt++;
        press(1'b1, 1'b1);
        chk_cnt++; if (dut.state_r !== EDIT_M) $display("FAIL simul_state: got %0d want %0d", dut.state_r, EDIT_M); else pass_cnt++;
        chk_cnt++; if (dut.edit_h_r !== 5'd9) $display("FAIL simul_edit_h: got %0d want 9", dut.edit_h_r); else pass_cnt++;
        chk_cnt++; if (dut.edit_m_r !== 6'd0) $display("FAIL simul_min_clamp: got %0d want 0", dut.edit_m_r); else pass_cnt++;
        chk_cnt++; if (blink_m !== 1'b1 || blink_h !== 1'b0) $display("FAIL simul_blink: got h%b m%b want h0 m1", blink_h, blink_m); else pass_cnt++;
    endtask

    task automatic test_reset_mid_commit();
        logic load_seen;
        s_en = 1'b0;
        hour = 5'd5;
        min  = 6'd7;
        apply_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk_cnt++; if (reset_h !== 1'b1 || reset_m !== 1'b0) $display("FAIL mid_commit_h: rh%b rm%b want rh1 rm0", reset_h, reset_m); else pass_cnt++;
        chk_cnt++; if (set !== 6'd5 || enable !== 1'b1) $display("FAIL mid_commit_set: set %0d en %b want 5 1", set, enable); else pass_cnt++;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk_cnt++; if (reset_h !== 1'b0 || set !== 6'd0) $display("FAIL mid_reset_loads: rh %b set %0d want 0 0", reset_h, set); else pass_cnt++;
        chk_cnt++; if (enable !== 1'b1 || dut.state_r !== RUN) $display("FAIL mid_reset_state: en %b state %0d want 1 0", enable, dut.state_r); else pass_cnt++;
        load_seen = 1'b0;
        s_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (reset_h === 1'b1 || reset_m === 1'b1) load_seen = 1'b1;
        end
        chk_cnt++; if (load_seen !== 1'b0) $display("FAIL mid_reset_noload: got %b want 0", load_seen); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_full_set();
        test_timeout();
        test_simultaneous();
        test_reset_mid_commit();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
